// File: rtl/eep_sched.sv
// EEPROM access scheduler: arbitrates control-loop reads and config reads/writes
// onto a single EEPROM port, with timed chip-select windows and a recovery cycle.
module eep_sched #(
    parameter int unsigned RD_CYC = 2,
    parameter int unsigned WR_CYC = 2400000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lp_req,
    input  logic [1:0]  lp_addr,
    output logic        lp_ack,
    output logic [13:0] lp_rdata,
    input  logic        cf_req,
    input  logic        cf_wr,
    input  logic [1:0]  cf_addr,
    input  logic [13:0] cf_wdata,
    output logic        cf_ack,
    output logic [13:0] cf_rdata,
    input  logic [13:0] eep_rd_data,
    output logic [1:0]  eep_addr,
    output logic [13:0] eep_wdata,
    output logic        eep_cs_n,
    output logic        eep_r_w_n,
    output logic        chrg_pmp_en,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RECOV} state_t;

    localparam logic [21:0] RD_LOAD = 22'(RD_CYC);
    localparam logic [21:0] WR_LOAD = 22'(WR_CYC);

    state_t      r_state;
    state_t      w_next;
    logic [21:0] r_cnt;
    logic        r_prio_cf;   // 1: cf wins the next tie
    logic        r_own_cf;    // current/last operation belongs to cf
    logic [1:0]  r_addr;
    logic [13:0] r_wdata;
    logic [13:0] r_lp_rdata;
    logic [13:0] r_cf_rdata;
    logic        w_gnt_lp;
    logic        w_gnt_cf;
    logic        w_last;

    // Arbitration: requests only considered in IDLE, round-robin on a tie
    always_comb begin
        w_gnt_lp = 1'b0;
        w_gnt_cf = 1'b0;
        if (r_state == S_IDLE) begin
            if (lp_req && cf_req) begin
                w_gnt_cf = r_prio_cf;
                w_gnt_lp = !r_prio_cf;
            end else begin
                w_gnt_lp = lp_req;
                w_gnt_cf = cf_req;
            end
        end
    end

    assign w_last = (r_cnt == 22'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_gnt_lp || (w_gnt_cf && !cf_wr)) w_next = S_READ;
                else if (w_gnt_cf)                    w_next = S_WRITE;
            end
            S_READ, S_WRITE: begin
                if (w_last) w_next = S_RECOV;
            end
            S_RECOV: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Cycle counter: load at grant, count down to terminal 1, saturate at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_gnt_lp || (w_gnt_cf && !cf_wr)) begin
            r_cnt <= RD_LOAD;
        end else if (w_gnt_cf) begin
            r_cnt <= WR_LOAD;
        end else if ((r_state == S_READ || r_state == S_WRITE) && r_cnt != '0) begin
            r_cnt <= r_cnt - 22'd1;
        end
    end

    // Grant bookkeeping: owner, round-robin pointer, latched address and write data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_cf <= 1'b0;
            r_own_cf  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else if (w_gnt_lp) begin
            r_prio_cf <= 1'b1;
            r_own_cf  <= 1'b0;
            r_addr    <= lp_addr;
        end else if (w_gnt_cf) begin
            r_prio_cf <= 1'b0;
            r_own_cf  <= 1'b1;
            r_addr    <= cf_addr;
            if (cf_wr) r_wdata <= cf_wdata;
        end
    end

    // Read data capture on the last READ cycle, held until the owner's next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lp_rdata <= '0;
            r_cf_rdata <= '0;
        end else if (r_state == S_READ && w_last) begin
            if (r_own_cf) r_cf_rdata <= eep_rd_data;
            else          r_lp_rdata <= eep_rd_data;
        end
    end

    // Strobes decode straight from the state so reset drops them asynchronously
    assign eep_cs_n    = !(r_state == S_READ || r_state == S_WRITE);
    assign eep_r_w_n   = (r_state != S_WRITE);
    assign chrg_pmp_en = (r_state == S_WRITE);
    assign busy        = (r_state != S_IDLE);
    assign lp_ack      = (r_state == S_RECOV) && !r_own_cf;
    assign cf_ack      = (r_state == S_RECOV) && r_own_cf;
    assign eep_addr    = r_addr;
    assign eep_wdata   = r_wdata;
    assign lp_rdata    = r_lp_rdata;
    assign cf_rdata    = r_cf_rdata;

endmodule

// File: doc/eep_sched.md
EEP_SCHED -- requirements
Module: eep_sched

Interface
REQ-001 SHALL have parameter RD_CYC, default 2, meaning the number of cycles an EEPROM read holds chip select before the data sample (legal 1..15).
REQ-002 SHALL have parameter WR_CYC, default 2400000, meaning the number of cycles a write holds chip select and the charge pump (3 ms at 800 MHz; legal 2..2^22-1).
REQ-003 SHALL have ports, one per line:
  clk  input  1  system clock (800 MHz);
  rst_n  input  1  asynchronous active-low reset;
  lp_req  input  1  control-loop read request, level, held until lp_ack;
  lp_addr  input  2  control-loop read address;
  lp_ack  output  1  one-cycle pulse, lp_rdata valid;
  lp_rdata  output  14  control-loop read data;
  cf_req  input  1  config request, level, held until cf_ack;
  cf_wr  input  1  config op: 1 = write, 0 = read;
  cf_addr  input  2  config address;
  cf_wdata  input  14  config write data;
  cf_ack  output  1  one-cycle pulse, op complete, cf_rdata valid on reads;
  cf_rdata  output  14  config read data;
  eep_rd_data  input  14  EEPROM read data;
  eep_addr  output  2  EEPROM address;
  eep_wdata  output  14  EEPROM write data;
  eep_cs_n  output  1  active-low chip select;
  eep_r_w_n  output  1  1 = read, 0 = write;
  chrg_pmp_en  output  1  charge-pump enable, writes only;
  busy  output  1  high in any state but IDLE.

Function
REQ-004 SHALL implement states IDLE, READ, WRITE, RECOV.
REQ-005 In IDLE with exactly one request high, SHALL grant it on that clock edge, latch its address (and cf_wdata, cf_wr), and enter READ (lp, or cf with cf_wr=0) or WRITE (cf with cf_wr=1).
REQ-006 With lp_req and cf_req both high in IDLE, SHALL grant the requester not granted most recently (round-robin); after reset the first tie goes to lp.
REQ-007 In READ: eep_cs_n=0, eep_r_w_n=1, eep_addr=latched address, for exactly RD_CYC cycles; eep_rd_data SHALL be sampled on the last READ cycle.
REQ-008 In WRITE: eep_cs_n=0, eep_r_w_n=0, chrg_pmp_en=1, eep_addr and eep_wdata=latched values, for exactly WR_CYC cycles.
REQ-009 chrg_pmp_en SHALL never be high outside WRITE; eep_r_w_n SHALL be 1 outside WRITE.
REQ-010 After READ or WRITE, SHALL spend exactly one RECOV cycle with eep_cs_n=1, then return to IDLE.
REQ-011 The matching ack SHALL pulse high for exactly one cycle, during RECOV; the matching rdata register SHALL hold the sampled word from that cycle until the next read for that requester.
REQ-012 Read latency: grant edge to ack = RD_CYC+1 cycles; write: WR_CYC+1 cycles; minimum spacing between successive grants = RD_CYC+2 cycles.
REQ-013 A request SHALL be evaluated only in IDLE; requests arriving mid-operation SHALL wait, and changes to address/data inputs after grant SHALL not affect the operation.
REQ-014 A requester dropping its req mid-operation SHALL not abort the operation; its ack still pulses.
REQ-015 A requester that keeps req high in the cycle after its ack SHALL be treated as a new request.
REQ-016 The cycle counter SHALL be 22 bits, load at grant, decrement, and never wrap; terminal count is 1.
REQ-017 eep_wdata SHALL hold the last written value outside WRITE.

Reset
REQ-018 On rst_n low, asynchronously: state=IDLE, eep_cs_n=1, eep_r_w_n=1, chrg_pmp_en=0, eep_addr=0, eep_wdata=0, lp_ack=0, cf_ack=0, lp_rdata=0, cf_rdata=0, busy=0, counter=0, round-robin pointer=lp.
REQ-019 Reset during WRITE SHALL drop chrg_pmp_en and eep_cs_n immediately; no ack is issued for the aborted op.

Verification
REQ-020 lp_req=1, lp_addr=2, eep_rd_data=0x1ABC -> cs_n low 2 cycles, lp_ack at cycle 3 after grant, lp_rdata=0x1ABC.
REQ-021 cf write addr=1, data=0x2F0F, WR_CYC=10 -> cs_n=0, r_w_n=0, chrg_pmp_en=1 for exactly 10 cycles, eep_wdata=0x2F0F, cf_ack 1 cycle later.
REQ-022 lp_req and cf_req held continuously -> grants alternate lp, cf, lp, cf; neither starved.
REQ-023 cf_req raised during lp READ -> waits; granted on the first IDLE cycle after RECOV.
REQ-024 rst_n low at cycle 5 of a 10-cycle write -> chrg_pmp_en=0, cs_n=1 same cycle; no cf_ack; busy=0.
REQ-025 lp_req held after lp_ack -> second read granted, spacing between grants = RD_CYC+2 = 4 cycles.
